// File: rtl/uart_rx_apb_ctrl_pkg.sv
// Shared widths, register map and helpers for the UART RX APB
// sequencer and its APB master sub-block.
package uart_rx_apb_ctrl_pkg;

  localparam int APB_ADDR_WD          = 8;
  localparam int APB_DATA_WD          = 32;
  localparam int UART_NUMB_DIV_CLK_WD = 16;
  localparam int UART_NUMB_BIT_WD     = 4;
  localparam int UART_ENUM_PARITY_WD  = 2;
  localparam int UART_SIZE_STOP_WD    = 2;
  localparam int UART_NUMB_BIT_MAX    = 8;

  localparam logic [APB_ADDR_WD-1:0] UART_CFG_DIV_CLK = 8'h00;
  localparam logic [APB_ADDR_WD-1:0] UART_CFG_NUM_BIT = 8'h04;
  localparam logic [APB_ADDR_WD-1:0] UART_CFG_PARITY  = 8'h08;
  localparam logic [APB_ADDR_WD-1:0] UART_CFG_STOP    = 8'h0C;
  localparam logic [APB_ADDR_WD-1:0] UART_FDB_DATA    = 8'h10;

  function automatic logic [APB_ADDR_WD-1:0] cfg_addr(
    input logic [1:0] idx
  );
    logic [APB_ADDR_WD-1:0] a;
    a = UART_CFG_DIV_CLK;
    unique case (idx)
      2'd0: a = UART_CFG_DIV_CLK;
      2'd1: a = UART_CFG_NUM_BIT;
      2'd2: a = UART_CFG_PARITY;
      2'd3: a = UART_CFG_STOP;
      default: a = UART_CFG_DIV_CLK;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/uart_rx_apb_ctrl_xfer.sv
// Two-phase APB master: SETUP/ACCESS driven by the caller, ack
// returned on write ACCESS or RD_LAT cycles after a read ACCESS.
module apb_mst_xfer
  import uart_rx_apb_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_setup,
  input  logic                   i_access,
  input  logic [APB_ADDR_WD-1:0] i_addr,
  input  logic                   i_wr,
  input  logic [APB_DATA_WD-1:0] i_wdata,
  output logic [APB_ADDR_WD-1:0] o_paddr,
  output logic                   o_psel,
  output logic                   o_penable,
  output logic                   o_pwrite,
  output logic [APB_DATA_WD-1:0] o_pwdata,
  input  logic [APB_DATA_WD-1:0] i_prdata,
  output logic                   o_ack,
  output logic [APB_DATA_WD-1:0] o_rdata
);

  logic [1:0] r_cnt;
  logic       r_wait;
  logic       w_sel;

  assign w_sel     = i_setup | i_access;
  assign o_psel    = w_sel;
  assign o_penable = i_access;
  assign o_paddr   = w_sel ? i_addr : '0;
  assign o_pwrite  = w_sel & i_wr;
  assign o_pwdata  = (w_sel & i_wr) ? i_wdata : '0;
  assign o_rdata   = i_prdata;

  assign o_ack = (i_access & (i_wr | (RD_LAT == 0)))
               | (r_wait & (r_cnt == 2'd0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait <= 1'b0;
      r_cnt  <= 2'd0;
    end else if (i_access && !i_wr && RD_LAT != 0) begin
      r_wait <= 1'b1;
      r_cnt  <= 2'(RD_LAT - 1);
    end else if (r_wait) begin
      if (r_cnt == 2'd0) r_wait <= 1'b0;
      else               r_cnt  <= r_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/uart_rx_apb_ctrl.sv
// APB sequencer: programs the UART RX config registers, then
// drains the RX FIFO into a valid/ready byte stream.
module uart_rx_apb_ctrl
  import uart_rx_apb_ctrl_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int NUM_RD_WD = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start_i,
  input  logic                            stop_i,
  input  logic [UART_NUMB_DIV_CLK_WD-1:0] cfg_num_div_clk_i,
  input  logic [UART_NUMB_BIT_WD-1:0]     cfg_num_bit_i,
  input  logic [UART_ENUM_PARITY_WD-1:0]  cfg_enm_parity_i,
  input  logic [UART_SIZE_STOP_WD-1:0]    cfg_siz_stop_i,
  input  logic [NUM_RD_WD-1:0]            cfg_num_rd_i,
  output logic [APB_ADDR_WD-1:0]          paddr_o,
  output logic                            psel_o,
  output logic                            penable_o,
  output logic                            pwrite_o,
  output logic [APB_DATA_WD-1:0]          pwdata_o,
  input  logic [APB_DATA_WD-1:0]          prdata_i,
  input  logic                            ready_i,
  output logic                            val_o,
  output logic [UART_NUMB_BIT_MAX-1:0]    dat_o,
  input  logic                            rdy_i,
  output logic                            busy_o,
  output logic                            done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_SETUP, S_CFG_ACCESS, S_POLL,
    S_RD_SETUP, S_RD_ACCESS, S_RD_WAIT, S_OUT
  } state_e;

  state_e r_state, w_nxt;

  logic [UART_NUMB_DIV_CLK_WD-1:0] r_div;
  logic [UART_NUMB_BIT_WD-1:0]     r_bit;
  logic [UART_ENUM_PARITY_WD-1:0]  r_par;
  logic [UART_SIZE_STOP_WD-1:0]    r_stp;
  logic [NUM_RD_WD-1:0]            r_num_rd, r_cnt, w_cnt_nx;
  logic [1:0]                      r_idx;
  logic                            r_stop, r_done;
  logic [UART_NUMB_BIT_MAX-1:0]    r_dat;

  logic                   w_done, w_stop, w_ack, w_cap;
  logic                   w_setup, w_access, w_wr;
  logic [APB_ADDR_WD-1:0] w_addr;
  logic [APB_DATA_WD-1:0] w_wdata, w_rdata;
  logic                   w_unused;

  assign w_unused = ^w_rdata[APB_DATA_WD-1:UART_NUMB_BIT_MAX];

  assign w_stop   = r_stop | stop_i;
  assign w_cnt_nx = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_setup  = (r_state == S_CFG_SETUP) | (r_state == S_RD_SETUP);
  assign w_access = (r_state == S_CFG_ACCESS) | (r_state == S_RD_ACCESS);
  assign w_wr     = (r_state == S_CFG_SETUP) | (r_state == S_CFG_ACCESS);
  assign w_cap    = w_ack & ((r_state == S_RD_ACCESS) | (r_state == S_RD_WAIT));

  always_comb begin
    w_addr  = UART_FDB_DATA;
    w_wdata = '0;
    if (w_wr) begin
      w_addr = cfg_addr(r_idx);
      unique case (r_idx)
        2'd0: w_wdata = APB_DATA_WD'(r_div);
        2'd1: w_wdata = APB_DATA_WD'(r_bit);
        2'd2: w_wdata = APB_DATA_WD'(r_par);
        2'd3: w_wdata = APB_DATA_WD'(r_stp);
        default: w_wdata = '0;
      endcase
    end
  end

  always_comb begin
    w_nxt  = r_state;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE:       if (start_i) w_nxt = S_CFG_SETUP;
      S_CFG_SETUP:  w_nxt = S_CFG_ACCESS;
      S_CFG_ACCESS: w_nxt = (r_idx == 2'd3) ? S_POLL : S_CFG_SETUP;
      S_POLL: begin
        if (w_stop) begin
          w_nxt  = S_IDLE;
          w_done = 1'b1;
        end else if (ready_i) begin
          w_nxt = S_RD_SETUP;
        end
      end
      S_RD_SETUP:  w_nxt = S_RD_ACCESS;
      S_RD_ACCESS: w_nxt = w_ack ? S_OUT : S_RD_WAIT;
      S_RD_WAIT:   if (w_ack) w_nxt = S_OUT;
      S_OUT: begin
        if (rdy_i) begin
          if (((r_num_rd != '0) && (w_cnt_nx == r_num_rd)) || w_stop) begin
            w_nxt  = S_IDLE;
            w_done = 1'b1;
          end else begin
            w_nxt = S_POLL;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_par    <= '0;
      r_stp    <= '0;
      r_num_rd <= '0;
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_stop   <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_state <= w_nxt;
      r_done  <= w_done;
      if (r_state == S_IDLE && start_i) begin
        r_div    <= cfg_num_div_clk_i;
        r_bit    <= cfg_num_bit_i;
        r_par    <= cfg_enm_parity_i;
        r_stp    <= cfg_siz_stop_i;
        r_num_rd <= cfg_num_rd_i;
        r_cnt    <= '0;
        r_idx    <= 2'd0;
        r_stop   <= 1'b0;
      end else begin
        if (stop_i && r_state != S_IDLE) r_stop <= 1'b1;
        if (r_state == S_CFG_ACCESS) r_idx <= r_idx + 2'd1;
        if (w_cap) r_dat <= w_rdata[UART_NUMB_BIT_MAX-1:0];
        if (r_state == S_OUT && rdy_i) r_cnt <= w_cnt_nx;
        // a pending stop is consumed by the return to IDLE
        if (w_nxt == S_IDLE) r_stop <= 1'b0;
      end
    end
  end

  apb_mst_xfer #(.RD_LAT(RD_LAT)) u_xfer (
    .clk       (clk),
    .rstn      (rstn),
    .i_setup   (w_setup),
    .i_access  (w_access),
    .i_addr    (w_addr),
    .i_wr      (w_wr),
    .i_wdata   (w_wdata),
    .o_paddr   (paddr_o),
    .o_psel    (psel_o),
    .o_penable (penable_o),
    .o_pwrite  (pwrite_o),
    .o_pwdata  (pwdata_o),
    .i_prdata  (prdata_i),
    .o_ack     (w_ack),
    .o_rdata   (w_rdata)
  );

  assign val_o  = (r_state == S_OUT);
  assign dat_o  = r_dat;
  assign busy_o = (r_state != S_IDLE);
  assign done_o = r_done;

endmodule

// File: tb/tb_uart_rx_apb_ctrl.sv
// Bench for uart_rx_apb_ctrl: APB slave + FIFO model, byte
// scoreboard on the output stream, per-scenario tasks.
module tb_uart_rx_apb_ctrl;
  import uart_rx_apb_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, start_i, stop_i, ready_i, rdy_i;
  logic [15:0] div, num_rd;
  logic [3:0]  nbit;
  logic [1:0]  par, stp;
  logic [7:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        val_o, busy_o, done_o;
  logic [7:0]  dat_o;

  uart_rx_apb_ctrl #(.RD_LAT(1), .NUM_RD_WD(16)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .start_i           (start_i),
    .stop_i            (stop_i),
    .cfg_num_div_clk_i (div),
    .cfg_num_bit_i     (nbit),
    .cfg_enm_parity_i  (par),
    .cfg_siz_stop_i    (stp),
    .cfg_num_rd_i      (num_rd),
    .paddr_o           (paddr),
    .psel_o            (psel),
    .penable_o         (penable),
    .pwrite_o          (pwrite),
    .pwdata_o          (pwdata),
    .prdata_i          (prdata),
    .ready_i           (ready_i),
    .val_o             (val_o),
    .dat_o             (dat_o),
    .rdy_i             (rdy_i),
    .busy_o            (busy_o),
    .done_o            (done_o)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, oob_rd = 0, proto_err = 0;
  logic       prev_setup = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic [7:0] e;

  // APB slave, RX FIFO model and stream scoreboard, all mid-cycle
  always @(negedge clk) begin
    if (!rstn) begin
      prev_setup = 1'b0;
    end else begin
      if (prev_setup && !(psel && penable)) proto_err++;
      if (psel && val_o) oob_rd++;
      if (psel && !penable) begin
        prev_setup = 1'b1;
        prev_addr  = paddr;
      end else if (psel && penable) begin
        if (!prev_setup || prev_addr != paddr) proto_err++;
        prev_setup = 1'b0;
        if (pwrite) wr_cnt++;
        else if (paddr == UART_FDB_DATA && fifo.size() > 0) begin
          prdata = {24'h0, fifo.pop_front()};
          rd_cnt++;
        end
      end else begin
        prev_setup = 1'b0;
      end
      ready_i = (fifo.size() != 0);
      if (val_o && rdy_i) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra: got %h, required no word", dat_o);
        end else begin
          e = exp_q.pop_front();
          if (dat_o !== e) begin
            fails++;
            $display("FAIL stream_data: got %h, required %h", dat_o, e);
          end
        end
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    fifo.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (busy_o) begin
      fails++;
      $display("FAIL %s_timeout: busy %b after %0d cycles, required 0", nm, busy_o, n);
    end
  endtask

  // pulse start, then check all 8 configuration cycles
  task automatic check_cfg(input string nm);
    logic [7:0]  addrs[4];
    logic [31:0] wd[4];
    logic [42:0] got, exp;
    addrs[0] = UART_CFG_DIV_CLK; addrs[1] = UART_CFG_NUM_BIT;
    addrs[2] = UART_CFG_PARITY;  addrs[3] = UART_CFG_STOP;
    wd[0] = 32'(div); wd[1] = 32'(nbit);
    wd[2] = 32'(par); wd[3] = 32'(stp);
    pulse_start();
    tests++;
    if (busy_o !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy: got %b, required 1", nm, busy_o);
    end
    for (int i = 0; i < 8; i++) begin
      got = {psel, penable, pwrite, paddr, pwdata};
      exp = {1'b1, 1'(i % 2), 1'b1, addrs[i/2], wd[i/2]};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL %s_cyc%0d: got %h, required %h", nm, i, got, exp);
      end
      tick();
    end
    tests++;
    if (psel !== 1'b0) begin
      fails++;
      $display("FAIL %s_poll_psel: got %b, required 0", nm, psel);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(3);
    tests++;
    if ({psel, penable, pwrite, paddr, pwdata, val_o, dat_o, busy_o, done_o} !== '0) begin
      fails++;
      $display("FAIL reset_outs: got %b%b%b %h %h %b %h %b%b, required all 0",
               psel, penable, pwrite, paddr, pwdata, val_o, dat_o, busy_o, done_o);
    end
    rstn = 1'b1;
    tick(2);
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy %b, required 0", busy_o);
    end
  endtask

  task automatic test_config();
    int d0 = done_cnt;
    num_rd = 16'd0;
    check_cfg("cfg");
    pulse_stop();
    wait_idle(10, "cfg");
    tick(2);
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL cfg_done: got %0d pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_single();
    int r0 = rd_cnt, n = 0;
    num_rd = 16'd1;
    rdy_i  = 1'b1;
    pulse_start();
    push_frame(8'hA5);
    while (!(val_o && rdy_i) && n < 60) begin
      tick();
      n++;
    end
    tests++;
    if (!(val_o && rdy_i)) begin
      fails++;
      $display("FAIL single_hs_timeout: val %b, required 1", val_o);
    end
    tick();
    tests++;
    if ({done_o, busy_o} !== 2'b10) begin
      fails++;
      $display("FAIL single_done: done/busy %b%b, required 10", done_o, busy_o);
    end
    tests++;
    if (rd_cnt - r0 != 1) begin
      fails++;
      $display("FAIL single_reads: got %0d, required 1", rd_cnt - r0);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int r0, d0 = done_cnt, n = 0;
    num_rd = 16'd3;
    rdy_i  = 1'b0;
    push_frame(8'h11);
    push_frame(8'h22);
    push_frame(8'h33);
    pulse_start();
    while (!val_o && n < 60) begin
      tick();
      n++;
    end
    r0 = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (val_o !== 1'b1 || dat_o !== 8'h11 || rd_cnt != r0) begin
        fails++;
        $display("FAIL bp_hold%0d: val %b dat %h reads %0d, required 1 11 %0d",
                 i, val_o, dat_o, rd_cnt, r0);
      end
      tick();
    end
    rdy_i = 1'b1;
    wait_idle(80, "bp");
    tick(2);
    tests++;
    if (exp_q.size() != 0 || done_cnt - d0 != 1 || oob_rd != 0) begin
      fails++;
      $display("FAIL bp_end: left %0d done %0d oob %0d, required 0 1 0",
               exp_q.size(), done_cnt - d0, oob_rd);
    end
  endtask

  task automatic test_stop_cfg();
    int w0 = wr_cnt, r0 = rd_cnt, d0 = done_cnt;
    num_rd = 16'd0;
    pulse_start();
    tick(2);
    pulse_stop();
    wait_idle(30, "stopcfg");
    tick(2);
    tests++;
    if (wr_cnt - w0 != 4 || rd_cnt != r0 || done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL stopcfg: writes %0d reads %0d done %0d, required 4 0 1",
               wr_cnt - w0, rd_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_unlimited();
    int r0 = rd_cnt, d0 = done_cnt, n = 0;
    num_rd = 16'd0;
    rdy_i  = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) push_frame(8'(8'h40 + 8'(i * 7)));
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick(3);
    tests++;
    if (busy_o !== 1'b1 || done_cnt != d0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL unl_run: busy %b done %0d left %0d, required 1 0 0",
               busy_o, done_cnt - d0, exp_q.size());
    end
    pulse_stop();
    wait_idle(10, "unl");
    tick(2);
    tests++;
    if (done_cnt - d0 != 1 || rd_cnt - r0 != 5) begin
      fails++;
      $display("FAIL unl_end: done %0d reads %0d, required 1 5",
               done_cnt - d0, rd_cnt - r0);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    num_rd = 16'd1;
    rdy_i  = 1'b1;
    pulse_start();
    fifo.push_back(8'h5A);
    while (!(psel && penable && !pwrite) && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (!(psel && penable && !pwrite)) begin
      fails++;
      $display("FAIL rstmid_timeout: no read access seen, required one");
    end
    rstn = 1'b0;
    #1;
    tests++;
    if ({psel, penable, val_o, busy_o} !== 4'b0) begin
      fails++;
      $display("FAIL rstmid_async: psel/pen/val/busy %b%b%b%b, required 0000",
               psel, penable, val_o, busy_o);
    end
    fifo.delete();
    ready_i = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick();
    check_cfg("rstcfg");
    pulse_stop();
    wait_idle(10, "rstmid");
  endtask

  initial begin
    rstn = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    ready_i = 1'b0; rdy_i = 1'b0; prdata = 32'h0;
    div = 16'd434; nbit = 4'd8; par = 2'd0; stp = 2'd1;
    num_rd = 16'd0;
    test_reset();
    test_config();
    div = 16'd16;
    test_single();
    test_backpressure();
    test_stop_cfg();
    test_unlimited();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
